// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, NZCV flags, FSM states and
// the common flag-building function used by every result path.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_ORR  = 4'd3,
    ALU_EOR  = 4'd4,
    ALU_LSL  = 4'd5,
    ALU_LSR  = 4'd6,
    ALU_ASR  = 4'd7,
    ALU_MUL  = 4'd8,
    ALU_UDIV = 4'd9,
    ALU_SDIV = 4'd10
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_DONE
  } alu_state_t;

  // result must be zero-extended to 64 bits; width selects which bit is N.
  function automatic alu_flags_t alu_nzcv(input logic [63:0] result,
                                          input int unsigned width,
                                          input logic c, input logic v);
    alu_flags_t f;
    f.n = (result >> (width - 1)) != 64'd0;
    f.z = (result == 64'd0);
    f.c = c;
    f.v = v;
    return f;
  endfunction

endpackage

// File: rtl/seq_alu_div.sv
// Unsigned restoring radix-2 divider: loads on start, then performs exactly
// WIDTH iterations; done is high during the cycle of the final iteration.
module seq_alu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH);

  logic             running;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] den;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // Remainder stays below the divisor, so the trial difference fits WIDTH bits.
  always_comb begin
    shifted = {rem, quotient[WIDTH-1]};
    fits    = shifted >= {1'b0, den};
    trial   = shifted[WIDTH-1:0] - den;
  end

  assign done = running && (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: datapath registers are reset as well, so the quotient seen
      // after reset is a defined value rather than X.
      running  <= 1'b0;
      count    <= '0;
      rem      <= '0;
      den      <= '0;
      quotient <= '0;
    end else if (start) begin
      running  <= 1'b1;
      count    <= '0;
      rem      <= '0;
      den      <= divisor;
      quotient <= dividend;
    end else if (running) begin
      rem      <= fits ? trial : shifted[WIDTH-1:0];
      quotient <= {quotient[WIDTH-2:0], fits};
      count    <= count + CW'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops finish in one
// cycle, divides iterate in seq_alu_div; results hold until accepted.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output alu_flags_t       out_flags,
  output logic             out_err,
  output logic             busy
);

  alu_state_t       state, state_nx;
  logic             accept, is_div_op, sdiv_op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum, diff, lsl_ext, lsr_ext, asr_ext;
  logic [WIDTH-1:0] alu_res, res_q, dvd, dvs, div_quot, div_res;
  alu_flags_t       alu_flags, flags_q;
  logic             alu_c, alu_v, alu_err, err_q;
  logic             is_div_q, neg_q, dz_q, div_done;

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_div_op = (in_op == ALU_UDIV) || (in_op == ALU_SDIV);
  assign sdiv_op   = (in_op == ALU_SDIV);
  assign shamt     = in_b[SHW-1:0];

  // Shifts carry one guard bit so the last bit shifted out lands at a fixed position.
  always_comb begin
    sum     = {1'b0, in_a} + {1'b0, in_b};
    diff    = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH + 1)'(1);
    lsl_ext = {1'b0, in_a} << shamt;
    lsr_ext = {in_a, 1'b0} >> shamt;
    asr_ext = $signed({in_a, 1'b0}) >>> shamt;
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and infers a latch.
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (in_op)
      ALU_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      ALU_AND: alu_res = in_a & in_b;
      ALU_ORR: alu_res = in_a | in_b;
      ALU_EOR: alu_res = in_a ^ in_b;
      ALU_LSL: begin
        alu_res = lsl_ext[WIDTH-1:0];
        alu_c   = lsl_ext[WIDTH];
      end
      ALU_LSR: begin
        alu_res = lsr_ext[WIDTH:1];
        alu_c   = lsr_ext[0];
      end
      ALU_ASR: begin
        alu_res = asr_ext[WIDTH:1];
        alu_c   = asr_ext[0];
      end
      ALU_MUL:  alu_res = in_a * in_b;
      ALU_UDIV, ALU_SDIV: alu_res = '0;
      default: begin
        alu_res = '1;
        alu_err = 1'b1;
      end
    endcase
    alu_flags = alu_err ? alu_flags_t'('0) : alu_nzcv(64'(alu_res), WIDTH, alu_c, alu_v);
  end

  // The divider works on magnitudes; the sign is restored on the way out.
  assign dvd = (sdiv_op && in_a[WIDTH-1]) ? -in_a : in_a;
  assign dvs = (sdiv_op && in_b[WIDTH-1]) ? -in_b : in_b;

  seq_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && is_div_op),
    .dividend (dvd),
    .divisor  (dvs),
    .done     (div_done),
    .quotient (div_quot)
  );

  assign div_res = dz_q ? '0 : (neg_q ? -div_quot : div_quot);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = is_div_op ? ST_DIV : ST_DONE;
      ST_DIV:  if (div_done) state_nx = ST_DONE;
      ST_DONE: begin
        if (accept)         state_nx = is_div_op ? ST_DIV : ST_DONE;
        else if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      res_q    <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        is_div_q <= is_div_op;
        neg_q    <= sdiv_op && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        dz_q     <= (in_b == '0);
        res_q    <= alu_res;
        flags_q  <= alu_flags;
        err_q    <= alu_err;
      end
    end
  end

  assign out_valid  = (state == ST_DONE);
  assign busy       = (state == ST_DIV);
  assign out_result = is_div_q ? div_res : res_q;
  assign out_flags  = is_div_q ? alu_nzcv(64'(div_res), WIDTH, 1'b0, 1'b0) : flags_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results are queued at issue time
// and popped as the DUT presents them; a 16-bit instance covers narrow width.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_err, busy;
  alu_op_t     in_op = ALU_ADD;
  logic [31:0] in_a = '0, in_b = '0, out_result;
  alu_flags_t  out_flags;

  logic        h_in_valid = 1'b0, h_out_ready = 1'b1;
  logic        h_in_ready, h_out_valid, h_out_err, h_busy;
  alu_op_t     h_in_op = ALU_ADD;
  logic [15:0] h_in_a = '0, h_in_b = '0, h_out_result;
  alu_flags_t  h_out_flags;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flags;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t sb16[$];
  int   errors = 0;
  int   checks = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .out_err(out_err), .busy(busy)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_op(h_in_op), .in_a(h_in_a), .in_b(h_in_b), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .out_result(h_out_result), .out_flags(h_out_flags),
    .out_err(h_out_err), .busy(h_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    logic [63:0] p;
    logic [31:0] t;
    longint      sa, sbv, sd;
    int          sh;
    logic        c, v;
    e = '0; c = 1'b0; v = 1'b0;
    sh  = int'(b[4:0]);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b}; e.res = s[31:0]; c = s[32];
        sd = sa + sbv; v = (sd != longint'($signed(e.res)));
      end
      4'd1: begin
        e.res = a - b; c = (a >= b);
        sd = sa - sbv; v = (sd != longint'($signed(e.res)));
      end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: begin
        e.res = a << sh;
        if (sh != 0) begin t = a >> (32 - sh); c = t[0]; end
      end
      4'd6, 4'd7: begin
        e.res = (op == 4'd6) ? (a >> sh) : 32'($signed(a) >>> sh);
        if (sh != 0) begin t = a >> (sh - 1); c = t[0]; end
      end
      4'd8: begin p = {32'd0, a} * {32'd0, b}; e.res = p[31:0]; end
      4'd9: e.res = (b == 0) ? 32'd0 : a / b;
      4'd10: e.res = (b == 0) ? 32'd0 : 32'(sa / sbv);
      default: begin
        e.res = 32'hFFFF_FFFF; e.flags = 4'b0000; e.err = 1'b1;
        return e;
      end
    endcase
    e.flags = {e.res[31], (e.res == 32'd0), c, v};
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Issues one request from IDLE and waits for its result with out_ready high.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int busy_exp, input string name);
    exp_t e;
    int   n, bc;
    in_op = alu_op_t'(op); in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    sb.push_back(model(op, a, b));
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    n = 0; bc = 0;
    do begin
      tick(); n++;
      if (n == 1) begin
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
        in_op = alu_op_t'(4'($urandom_range(0, 15)));
      end
      if (busy === 1'b1) bc++;
    end while (out_valid !== 1'b1 && n < 100);
    e = sb.pop_front();
    checks++;
    if (n != lat || out_valid !== 1'b1) begin
      errors++; $display("FAIL %s latency: got %0d want %0d (out_valid=%b)", name, n, lat, out_valid);
    end
    checks++;
    if (bc != busy_exp) begin
      errors++; $display("FAIL %s busy cycles: got %0d want %0d", name, bc, busy_exp);
    end
    checks++;
    if (out_result !== e.res) begin
      errors++; $display("FAIL %s result: got %h want %h", name, out_result, e.res);
    end
    checks++;
    if (out_flags !== e.flags) begin
      errors++; $display("FAIL %s flags: got %b want %b", name, out_flags, e.flags);
    end
    checks++;
    if (out_err !== e.err) begin
      errors++; $display("FAIL %s err: got %b want %b", name, out_err, e.err);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset out_err: got %b want 0", out_err); end
    checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL reset out_result: got %h want 0", out_result); end
    checks++; if (out_flags !== 4'b0000) begin errors++; $display("FAIL reset out_flags: got %b want 0000", out_flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_single_cycle();
    run_op(4'd0, 32'd1, 32'd2, 1, 0, "add_small");
    run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 1, 0, "add_ovf");
    run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 1, 0, "add_carry");
    run_op(4'd1, 32'd5, 32'd7, 1, 0, "sub_borrow");
    run_op(4'd1, 32'h8000_0000, 32'd1, 1, 0, "sub_ovf");
    run_op(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 0, "and");
    run_op(4'd3, 32'hF000_0000, 32'h0000_000F, 1, 0, "orr");
    run_op(4'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1, 0, "eor_zero");
    run_op(4'd5, 32'h8000_0001, 32'd0, 1, 0, "lsl_0");
    run_op(4'd5, 32'h8000_0001, 32'd1, 1, 0, "lsl_1");
    run_op(4'd5, 32'h0000_0003, 32'd31, 1, 0, "lsl_31");
    run_op(4'd6, 32'h0000_0003, 32'd1, 1, 0, "lsr_1");
    run_op(4'd6, 32'h8000_0000, 32'd0, 1, 0, "lsr_0");
    run_op(4'd7, 32'h8000_0008, 32'd4, 1, 0, "asr_4");
    run_op(4'd8, 32'd1234, 32'd5678, 1, 0, "mul");
    run_op(4'd11, 32'd1, 32'd2, 1, 0, "undef_11");
    run_op(4'd15, 32'd0, 32'd0, 1, 0, "undef_15");
  endtask

  task automatic test_divide();
    run_op(4'd9, 32'd100, 32'd7, 33, 32, "udiv_100_7");
    run_op(4'd10, 32'hFFFF_FFF9, 32'd2, 33, 32, "sdiv_neg7_2");
    run_op(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32, "sdiv_min_m1");
    run_op(4'd9, 32'd5, 32'd0, 33, 32, "udiv_by_zero");
    run_op(4'd10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32, "sdiv_neg_neg");
    run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 33, 32, "udiv_max_1");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; in_op = ALU_ADD;
        in_a = 32'(i * 10 + 1); in_b = 32'hFFFF_FFF0 + 32'(i);
        sb.push_back(model(4'd0, in_a, in_b));
      end else begin
        in_valid = 1'b0;
      end
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_result !== e.res || out_flags !== e.flags) begin
          errors++;
          $display("FAIL b2b[%0d]: got valid=%b res=%h flags=%b want valid=1 res=%h flags=%b",
                   i - 1, out_valid, out_result, out_flags, e.res, e.flags);
        end
      end
      #1;
      if (i < 4) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b in_ready[%0d]: got %b want 1", i, in_ready); end
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b drain out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    exp_t e;
    in_valid = 1'b1; in_op = ALU_MUL; in_a = 32'h0001_0000; in_b = 32'h0001_0000; out_ready = 1'b0;
    sb.push_back(model(4'd8, in_a, in_b));
    tick();
    in_op = ALU_ADD; in_a = 32'd2; in_b = 32'd3;
    sb.push_back(model(4'd0, in_a, in_b));
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== sb[0].res || out_flags !== sb[0].flags || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: got valid=%b res=%h flags=%b in_ready=%b want valid=1 res=%h flags=%b in_ready=0",
                 k, out_valid, out_result, out_flags, in_ready, sb[0].res, sb[0].flags);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall release in_ready: got %b want 1", in_ready); end
    e = sb.pop_front();
    checks++;
    if (out_result !== e.res || out_flags !== e.flags || out_err !== e.err) begin
      errors++; $display("FAIL stall mul: got res=%h flags=%b err=%b want res=%h flags=%b err=%b",
                         out_result, out_flags, out_err, e.res, e.flags, e.err);
    end
    tick();
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_result !== e.res || out_flags !== e.flags) begin
      errors++; $display("FAIL stall follow-on add: got valid=%b res=%h flags=%b want valid=1 res=%h flags=%b",
                         out_valid, out_result, out_flags, e.res, e.flags);
    end
    tick();
  endtask

  task automatic test_reset_during_div();
    int seen;
    seen = 0;
    in_valid = 1'b1; in_op = ALU_UDIV; in_a = 32'd1000; in_b = 32'd3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL div reset state: got busy=%b out_valid=%b in_ready=%b want 0 0 1",
                         busy, out_valid, in_ready);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL div reset spurious out_valid: got %0d cycles want 0", seen); end
    run_op(4'd0, 32'd2, 32'd3, 1, 0, "add_after_reset");
  endtask

  task automatic run16(input alu_op_t op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic [3:0] flags, input string name);
    exp_t e;
    int   n;
    h_in_valid = 1'b1; h_in_op = op; h_in_a = a; h_in_b = b; h_out_ready = 1'b1;
    sb16.push_back({16'd0, res, flags, 1'b0});
    n = 0;
    do begin
      tick(); n++;
      h_in_valid = 1'b0;
    end while (h_out_valid !== 1'b1 && n < 10);
    e = sb16.pop_front();
    checks++;
    if (n != 1 || h_out_result !== e.res[15:0] || h_out_flags !== e.flags || h_out_err !== e.err) begin
      errors++;
      $display("FAIL %s: got lat=%0d res=%h flags=%b err=%b want lat=1 res=%h flags=%b err=%b",
               name, n, h_out_result, h_out_flags, h_out_err, e.res[15:0], e.flags, e.err);
    end
    tick();
  endtask

  task automatic test_width16();
    run16(ALU_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, "w16_add_carry");
    run16(ALU_LSL, 16'h8000, 16'h0001, 16'h0000, 4'b0110, "w16_lsl_out");
    run16(ALU_ASR, 16'h8000, 16'h000F, 16'hFFFF, 4'b1000, "w16_asr_15");
  endtask

  initial begin
    tick();
    test_reset();
    test_single_cycle();
    test_divide();
    test_back_to_back();
    test_stall();
    test_reset_during_div();
    test_width16();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard leftover: got %0d entries want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be a power of two, 8 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from in_b[SHW-1:0].
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset; synchronous and active-low.
REQ-005 Port in_valid  input  1  request valid.
REQ-006 Port in_ready  output  1  block accepts a request this cycle.
REQ-007 Port in_op  input  alu_op_t (4)  operation code.
REQ-008 Port in_a / in_b  input  WIDTH each  operands A and B.
REQ-009 Port out_valid  output  1  result valid.
REQ-010 Port out_ready  input  1  consumer accepts the result.
REQ-011 Port out_result  output  WIDTH  result.
REQ-012 Port out_flags  output  alu_flags_t (4)  NZCV.
REQ-013 Port out_err  output  1  result came from an undefined opcode.
REQ-014 Port busy  output  1  a divide is iterating.

Function
REQ-015 A request is accepted on a rising edge with in_valid and in_ready both high; in_op, in_a and in_b SHALL be captured then; later input changes SHALL be ignored.
REQ-016 FSM states: IDLE, DIV, DONE. in_ready SHALL equal (IDLE) or (DONE and out_ready), so back-to-back single-cycle ops run at full rate.
REQ-017 ADD, SUB, AND, ORR, EOR, LSL, LSR, ASR and MUL SHALL go from accept to DONE, with out_valid high the next cycle (latency 1).
REQ-018 UDIV and SDIV SHALL enter DIV and run a restoring radix-2 divide of exactly WIDTH iterations, with out_valid high WIDTH+1 cycles after accept.
REQ-019 In DONE, out_valid SHALL be 1, and out_result, out_flags and out_err SHALL hold stable until a cycle with out_ready high.
REQ-020 On handshake, the block SHALL go to IDLE, or accept a new request in the same cycle if in_valid is high.
REQ-021 ADD: C SHALL be the carry-out; V SHALL be set on same-sign operands giving a different-sign result.
REQ-022 SUB: C SHALL be the inverted borrow (1 means no borrow); V SHALL be set on different-sign operands where the result sign differs from A.
REQ-023 LSL: C SHALL be the last bit shifted out, or 0 when the shift is 0; V = 0.
REQ-024 LSR and ASR: C SHALL be in_a[shift-1], or 0 when the shift is 0; V = 0.
REQ-025 AND, ORR, EOR: C = 0, V = 0.
REQ-026 MUL: the result SHALL be the low WIDTH bits of the product; C = 0, V = 0.
REQ-027 UDIV and SDIV: the result SHALL be the quotient truncated toward zero; C = 0, V = 0.
REQ-028 N SHALL be result[WIDTH-1] and Z SHALL be (result == 0) for every defined opcode.
REQ-029 Divide by zero SHALL still take WIDTH+1 cycles and give result 0 (Z = 1) with out_err = 0.
REQ-030 SDIV of the most-negative value by -1 SHALL give the most-negative value (N = 1) with no error.
REQ-031 SDIV SHALL divide the operand magnitudes, then negate the quotient when the operand signs differ.
REQ-032 Opcodes 11 to 15 SHALL complete with latency 1, result all-ones, flags 0000 and out_err = 1.
REQ-033 busy SHALL be 1 exactly while in DIV; in_ready SHALL be 0 in DIV.

Reset
REQ-034 While rst_n is low at a rising edge: state SHALL become IDLE; out_valid, out_err and busy 0; out_result 0; out_flags 0000; in_ready SHALL read 1 after reset.
REQ-035 Reset during DIV or DONE SHALL drop the operation with no result delivered.

Structure
REQ-036 alu_pkg SHALL extend alu_op_t with ALU_MUL=8, ALU_UDIV=9, ALU_SDIV=10, keeping ADD..ASR at 0..7.
REQ-037 alu_pkg SHALL hold alu_flags_t, the state enum, and the shared combinational NZCV reference function.
REQ-038 The iterative divider SHALL be one sub-module, seq_alu_div, with a start/done interface and WIDTH parameter.

Verification (WIDTH=32 unless stated)
REQ-039 UDIV 100/7 -> 0x0000000E, NZCV 0000, out_valid 33 cycles after accept, busy high 32 cycles.
REQ-040 SDIV 0xFFFFFFF9/2 -> 0xFFFFFFFD, N = 1; SDIV 0x80000000/0xFFFFFFFF -> 0x80000000, N = 1; UDIV 5/0 -> 0, Z = 1.
REQ-041 WIDTH=16: ADD 0xFFFF+0x0001 -> 0x0000, NZCV 0110; LSL 0x8000 by 1 -> 0x0000, Z = 1, C = 1.
REQ-042 Four back-to-back ADDs with out_ready held 1 -> one result per cycle, in order.
REQ-043 out_ready low 5 cycles after MUL 0x10000*0x10000 -> 0x00000000, Z = 1, held stable; in_ready stays 0 until the handshake.
REQ-044 rst_n low at cycle 10 of a UDIV -> out_valid never asserted, IDLE next cycle, and the next ADD 2+3 returns 5.
